emergency_scheduler: RTL and testbench

EMERGENCY_SCHEDULER -- requirements
Module: emergency_scheduler

---
 rtl/traffic_pkg.sv | 44 ++++
 rtl/rr_arbiter4.sv | 39 +++
 rtl/emergency_scheduler.sv | 174 +++++++++++++++++
 tb/tb_emergency_scheduler.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// -----------------------------------------------------------------------------
// traffic_pkg
// Shared definitions for the emergency-vehicle pre-emption logic:
//   - intersection geometry (4 directions, 2 lanes per direction)
//   - scheduler state encoding
//   - helpers mapping directions to lane masks and lanes to direction requests
// No ports (package).
// -----------------------------------------------------------------------------
package traffic_pkg;

    localparam int unsigned NUM_DIRS      = 4;
    localparam int unsigned LANES_PER_DIR = 2;
    localparam int unsigned NUM_LANES     = NUM_DIRS * LANES_PER_DIR;

    typedef logic [1:0]           dir_t;
    typedef logic [NUM_DIRS-1:0]  dir_vec_t;
    typedef logic [NUM_LANES-1:0] lane_vec_t;

    typedef enum logic [1:0] {
        ST_NORMAL = 2'd0,
        ST_YELLOW = 2'd1,
        ST_ALLRED = 2'd2,
        ST_EGREEN = 2'd3
    } state_t;

    // Both lanes of direction d: bits 2d and 2d+1.
    function automatic lane_vec_t pair_mask(input dir_t dir);
        pair_mask = lane_vec_t'(2'b11) << {dir, 1'b0};
    endfunction

    // One-hot direction vector for direction d.
    function automatic dir_vec_t dir_onehot(input dir_t dir);
        dir_onehot = dir_vec_t'(1) << dir;
    endfunction

    // A direction requests when either of its lanes requests.
    function automatic dir_vec_t dir_req(input lane_vec_t lanes);
        dir_req = '0;
        for (int d = 0; d < NUM_DIRS; d++) begin
            dir_req[d] = lanes[2*d] | lanes[2*d+1];
        end
    endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// -----------------------------------------------------------------------------
// rr_arbiter4
// Purely combinational 4-way round-robin arbiter. The search starts at the
// direction after last_grant and wraps, so the previous winner has lowest
// priority.
// Ports:
//   req        in  4  request per direction
//   last_grant in  2  direction granted last time
//   winner     out 2  selected direction (last_grant when nothing is valid)
//   valid      out 1  at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter4
    import traffic_pkg::*;
(
    input  logic [NUM_DIRS-1:0] req,
    input  logic [1:0]          last_grant,
    output logic [1:0]          winner,
    output logic                valid
);

    logic [1:0] idx;

    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        winner = last_grant;
        valid  = 1'b0;
        idx    = '0;
        // Offsets 1..4: offset 4 wraps back to last_grant itself.
        for (int i = 1; i <= NUM_DIRS; i++) begin
            idx = last_grant + 2'(i);
            if (!valid && req[idx]) begin
                winner = idx;
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/emergency_scheduler.sv
// -----------------------------------------------------------------------------
// emergency_scheduler
// Overrides the normal signal controller when an emergency vehicle requests a
// direction: the current greens go yellow, then all-red, then the requesting
// direction gets both lanes green for at least MIN_GREEN cycles. Further
// requests are served round-robin straight from all-red before handing back
// to the normal controller.
// Ports:
//   clk            in  1  clock, rising edge
//   rst            in  1  synchronous active-high reset
//   emergency_lane in  8  per-lane emergency request (lanes 2d,2d+1 = dir d)
//   normal_green   in  8  green mask from the normal controller
//   lane_green     out 8  registered green mask to the lamps
//   lane_yellow    out 8  registered yellow mask to the lamps
//   preempt_active out 1  registered; high while normal_green is overridden
//   grant_dir      out 2  direction currently / last granted emergency green
// -----------------------------------------------------------------------------
module emergency_scheduler
    import traffic_pkg::*;
#(
    parameter int unsigned YELLOW_CYC = 4,
    parameter int unsigned ALLRED_CYC = 2,
    parameter int unsigned MIN_GREEN  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_LANES-1:0] emergency_lane,
    input  logic [NUM_LANES-1:0] normal_green,
    output logic [NUM_LANES-1:0] lane_green,
    output logic [NUM_LANES-1:0] lane_yellow,
    output logic                 preempt_active,
    output logic [1:0]           grant_dir
);

    // Counters are loaded with N-1 and the phase ends when they reach 0,
    // giving exactly N cycles per phase.
    localparam logic [7:0] YEL_LOAD = 8'(YELLOW_CYC - 1);
    localparam logic [7:0] AR_LOAD  = 8'(ALLRED_CYC - 1);
    localparam logic [7:0] MG_LOAD  = 8'(MIN_GREEN - 1);

    state_t    state_q,   state_d;
    logic [7:0] cnt_q,    cnt_d;
    lane_vec_t mask_q,    mask_d;
    dir_t      grant_q,   grant_d;
    dir_vec_t  pend_q,    pend_d;
    lane_vec_t green_q,   green_d;
    lane_vec_t yellow_q,  yellow_d;
    logic      preempt_q, preempt_d;

    dir_vec_t  dreq;
    dir_vec_t  arb_req;
    dir_t      arb_winner;
    logic      arb_valid;

    assign dreq = dir_req(emergency_lane);

    // Requests seen since the last grant are remembered, so a short pulse that
    // starts a clearance is still served when all-red ends. Arbitration sees
    // the remembered set plus whatever is live at that instant.
    assign arb_req = dreq | pend_q;

    rr_arbiter4 u_arb (
        .req        (arb_req),
        .last_grant (grant_q),
        .winner     (arb_winner),
        .valid      (arb_valid)
    );

    // Outputs are computed for the *next* state so they register on the same
    // edge as the state itself.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mask_d    = mask_q;
        grant_d   = grant_q;
        pend_d    = pend_q | dreq;
        green_d   = '0;
        yellow_d  = '0;
        preempt_d = 1'b1;

        unique case (state_q)
            ST_NORMAL: begin
                if (|arb_req) begin
                    state_d  = ST_YELLOW;
                    mask_d   = normal_green;
                    cnt_d    = YEL_LOAD;
                    yellow_d = normal_green;
                end else begin
                    green_d   = normal_green;
                    preempt_d = 1'b0;
                end
            end

            ST_YELLOW: begin
                if (cnt_q == 8'd0) begin
                    state_d = ST_ALLRED;
                    cnt_d   = AR_LOAD;
                end else begin
                    cnt_d    = cnt_q - 8'd1;
                    yellow_d = mask_q;
                end
            end

            ST_ALLRED: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else if (arb_valid) begin
                    state_d = ST_EGREEN;
                    grant_d = arb_winner;
                    cnt_d   = MG_LOAD;
                    green_d = pair_mask(arb_winner);
                    pend_d  = (pend_q | dreq) & ~dir_onehot(arb_winner);
                end else begin
                    state_d   = ST_NORMAL;
                    cnt_d     = 8'd0;
                    green_d   = normal_green;
                    preempt_d = 1'b0;
                end
            end

            ST_EGREEN: begin
                // The served direction's own request is not re-queued; it is
                // honoured by holding green instead.
                pend_d = (pend_q | dreq) & ~dir_onehot(grant_q);
                if (cnt_q != 8'd0) begin
                    cnt_d   = cnt_q - 8'd1;
                    green_d = pair_mask(grant_q);
                end else if (!dreq[grant_q]) begin
                    state_d  = ST_YELLOW;
                    mask_d   = pair_mask(grant_q);
                    cnt_d    = YEL_LOAD;
                    yellow_d = pair_mask(grant_q);
                end else begin
                    green_d = pair_mask(grant_q);
                end
            end

            default: begin
                state_d   = ST_NORMAL;
                preempt_d = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_NORMAL;
            cnt_q     <= 8'd0;
            mask_q    <= '0;
            grant_q   <= 2'd3;
            pend_q    <= '0;
            green_q   <= '0;
            yellow_q  <= '0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mask_q    <= mask_d;
            grant_q   <= grant_d;
            pend_q    <= pend_d;
            green_q   <= green_d;
            yellow_q  <= yellow_d;
            preempt_q <= preempt_d;
        end
    end

    assign lane_green     = green_q;
    assign lane_yellow    = yellow_q;
    assign preempt_active = preempt_q;
    assign grant_dir      = grant_q;

endmodule

// File: tb/tb_emergency_scheduler.sv
// -----------------------------------------------------------------------------
// tb_emergency_scheduler
// Directed, cycle-exact checks of the emergency scheduler with hand-computed
// lamp masks, followed by a random soak checking lamp exclusivity.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled at
// the same point, i.e. they show the result of the edge just taken.
// -----------------------------------------------------------------------------
module tb_emergency_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] emergency_lane;
    logic [7:0] normal_green;
    logic [7:0] lane_green;
    logic [7:0] lane_yellow;
    logic       preempt_active;
    logic [1:0] grant_dir;

    int n_cmp = 0;
    int n_bad = 0;

    emergency_scheduler #(
        .YELLOW_CYC (4),
        .ALLRED_CYC (2),
        .MIN_GREEN  (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .emergency_lane (emergency_lane),
        .normal_green   (normal_green),
        .lane_green     (lane_green),
        .lane_yellow    (lane_yellow),
        .preempt_active (preempt_active),
        .grant_dir      (grant_dir)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock, then compare green / yellow / preempt.
    task automatic cyc(input string tag, input logic [7:0] g, input logic [7:0] y, input logic p);
        @(posedge clk);
        #1;
        check({tag, ".green"},   lane_green,  g);
        check({tag, ".yellow"},  lane_yellow, y);
        check({tag, ".preempt"}, {7'd0, preempt_active}, {7'd0, p});
    endtask

    task automatic phase(input string tag, input int n, input logic [7:0] g,
                         input logic [7:0] y, input logic p);
        for (int i = 0; i < n; i++) cyc(tag, g, y, p);
    endtask

    task automatic gchk(input string tag, input logic [1:0] exp);
        check({tag, ".grant_dir"}, {6'd0, grant_dir}, {6'd0, exp});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] pair;

        // ---- reset ------------------------------------------------------
        rst            = 1'b1;
        emergency_lane = 8'h00;
        normal_green   = 8'hC0;
        @(negedge clk);
        cyc("reset", 8'h00, 8'h00, 1'b0);
        cyc("reset", 8'h00, 8'h00, 1'b0);
        gchk("reset", 2'd3);
        rst = 1'b0;

        // ---- dir 2 request (lane 5) at cycle 10, held into green --------
        phase("s1_normal", 9, 8'hC0, 8'h00, 1'b0);
        emergency_lane = 8'h20;
        phase("s1_yellow", 4, 8'h00, 8'hC0, 1'b1);
        phase("s1_allred", 2, 8'h00, 8'h00, 1'b1);
        cyc("s1_egreen", 8'h30, 8'h00, 1'b1);
        gchk("s1_egreen", 2'd2);
        emergency_lane = 8'h00;
        phase("s1_egreen", 7, 8'h30, 8'h00, 1'b1);
        phase("s1_exit_yellow", 4, 8'h00, 8'h30, 1'b1);
        phase("s1_exit_allred", 2, 8'h00, 8'h00, 1'b1);
        phase("s1_back", 2, 8'hC0, 8'h00, 1'b0);

        // ---- 1-cycle pulse on dir 0: exactly MIN_GREEN green ------------
        emergency_lane = 8'h02;
        cyc("s2_yellow", 8'h00, 8'hC0, 1'b1);
        emergency_lane = 8'h00;
        phase("s2_yellow", 3, 8'h00, 8'hC0, 1'b1);
        phase("s2_allred", 2, 8'h00, 8'h00, 1'b1);
        phase("s2_egreen", 8, 8'h03, 8'h00, 1'b1);
        gchk("s2_egreen", 2'd0);
        phase("s2_exit_yellow", 4, 8'h00, 8'h03, 1'b1);
        phase("s2_exit_allred", 2, 8'h00, 8'h00, 1'b1);
        phase("s2_back", 2, 8'hC0, 8'h00, 1'b0);

        // ---- pulse on dir 1 to leave grant_dir = 1 ----------------------
        emergency_lane = 8'h04;
        cyc("s3a_yellow", 8'h00, 8'hC0, 1'b1);
        emergency_lane = 8'h00;
        phase("s3a_yellow", 3, 8'h00, 8'hC0, 1'b1);
        phase("s3a_allred", 2, 8'h00, 8'h00, 1'b1);
        phase("s3a_egreen", 8, 8'h0C, 8'h00, 1'b1);
        gchk("s3a_egreen", 2'd1);
        phase("s3a_exit_yellow", 4, 8'h00, 8'h0C, 1'b1);
        phase("s3a_exit_allred", 2, 8'h00, 8'h00, 1'b1);
        phase("s3a_back", 2, 8'hC0, 8'h00, 1'b0);

        // ---- dirs 1 and 3 together: 3 first, then 1 with no NORMAL gap --
        emergency_lane = 8'h88;
        phase("s3b_yellow", 4, 8'h00, 8'hC0, 1'b1);
        phase("s3b_allred", 2, 8'h00, 8'h00, 1'b1);
        phase("s3b_egreen3", 10, 8'hC0, 8'h00, 1'b1);
        gchk("s3b_egreen3", 2'd3);
        emergency_lane = 8'h08;
        phase("s3b_clear3_yellow", 4, 8'h00, 8'hC0, 1'b1);
        phase("s3b_clear3_allred", 2, 8'h00, 8'h00, 1'b1);
        cyc("s3b_egreen1", 8'h0C, 8'h00, 1'b1);
        gchk("s3b_egreen1", 2'd1);
        emergency_lane = 8'h00;
        phase("s3b_egreen1", 7, 8'h0C, 8'h00, 1'b1);
        phase("s3b_exit_yellow", 4, 8'h00, 8'h0C, 1'b1);
        phase("s3b_exit_allred", 2, 8'h00, 8'h00, 1'b1);
        phase("s3b_back", 2, 8'hC0, 8'h00, 1'b0);

        // ---- reset in the middle of emergency green ---------------------
        emergency_lane = 8'h40;
        cyc("s4_yellow", 8'h00, 8'hC0, 1'b1);
        emergency_lane = 8'h00;
        phase("s4_yellow", 3, 8'h00, 8'hC0, 1'b1);
        phase("s4_allred", 2, 8'h00, 8'h00, 1'b1);
        phase("s4_egreen", 3, 8'hC0, 8'h00, 1'b1);
        gchk("s4_egreen", 2'd3);
        rst = 1'b1;
        cyc("s4_reset", 8'h00, 8'h00, 1'b0);
        gchk("s4_reset", 2'd3);
        rst          = 1'b0;
        normal_green = 8'h21;
        phase("s4_normal", 3, 8'h21, 8'h00, 1'b0);

        // ---- all-dark normal green still clears through yellow ----------
        normal_green   = 8'h00;
        emergency_lane = 8'h01;
        cyc("s5_yellow", 8'h00, 8'h00, 1'b1);
        emergency_lane = 8'h00;
        phase("s5_yellow", 3, 8'h00, 8'h00, 1'b1);
        phase("s5_allred", 2, 8'h00, 8'h00, 1'b1);
        phase("s5_egreen", 8, 8'h03, 8'h00, 1'b1);
        gchk("s5_egreen", 2'd0);
        phase("s5_exit_yellow", 4, 8'h00, 8'h03, 1'b1);
        phase("s5_exit_allred", 2, 8'h00, 8'h00, 1'b1);
        phase("s5_back", 2, 8'h00, 8'h00, 1'b0);

        // ---- random soak: lamp exclusivity and single-pair green --------
        for (int i = 0; i < 10000; i++) begin
            normal_green   = 8'($urandom);
            emergency_lane = ($urandom_range(0, 15) == 0) ? 8'($urandom) : 8'h00;
            @(posedge clk);
            #1;
            check("rnd_green_and_yellow", lane_green & lane_yellow, 8'h00);
            if (preempt_active && lane_green != 8'h00) begin
                pair = 8'b11 << (2 * grant_dir);
                check("rnd_egreen_pair", lane_green, pair);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
